// File: rtl/cyp_bridge_pkg.sv
// ---------------------------------------------------------------------------
// cyp_bridge_pkg
//   Shared definitions for the CY68013 (FX2) <-> SDRAM bridge blocks.
//   Contents:
//     tx_state_e   - state encoding of the SDRAM -> FX2 return path
//     FIFOADR_EP6  - FIFOADR value selecting the EP6 IN endpoint
//     FIFOADR_EP2  - FIFOADR value selecting the EP2 OUT endpoint
//     DATA_W_DEF   - default FX2 data bus / SDRAM word width
//     ADDR_W_DEF   - default SDRAM word-address width
// ---------------------------------------------------------------------------
package cyp_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEL   = 3'd1,
    ST_XFER  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } tx_state_e;

  localparam logic [1:0] FIFOADR_EP6 = 2'b10;
  localparam logic [1:0] FIFOADR_EP2 = 2'b00;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 22;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock first-word-fall-through FIFO used to absorb SDRAM read
//   returns before they are written into the FX2 slave FIFO.
//   DEPTH must be a power of two; count is one bit wider than the pointers so
//   that a completely full FIFO is representable.
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset (empties the FIFO)
//   push       in   write push_data this cycle
//   push_data  in   DATA_W word to store
//   pop        in   discard the head word this cycle
//   pop_data   out  current head word (valid while !empty)
//   count      out  number of stored words
//   empty      out  no words stored
//   full       out  DEPTH words stored
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 16,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign pop_data = mem[rd_ptr];

  // A push into a full FIFO is only honoured when a pop frees a slot in the
  // same cycle, so a misbehaving producer can never corrupt stored words.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  // Storage array carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/sdram2cyp_tx.sv
// ---------------------------------------------------------------------------
// sdram2cyp_tx
//   Return path of the USB bridge. Reads xfer_len 16-bit words from SDRAM
//   starting at base_addr and writes them into the FX2 EP6 IN slave FIFO with
//   synchronous SLWR strobes, pausing whenever FLAGB reports the endpoint full.
//   Read requests are throttled by a credit rule (outstanding reads plus
//   buffered words never exceed FIFO_DEPTH) so the non-stallable SDRAM return
//   stream always fits in the local FIFO.
//
//   Build option: define SDRAM2CYP_PKTEND_EN to pulse PKTEND after a transfer
//   whose length is not a multiple of PKT_WORDS (commits the short packet).
//   Without it PKTEND is held inactive and short packets wait for the host.
//
// Ports:
//   cyp_clk        in   FX2 IFCLK-domain clock
//   rst_n          in   asynchronous active-low reset
//   start          in   one-cycle start pulse, honoured only when idle
//   base_addr      in   first SDRAM word address (sampled on start)
//   xfer_len       in   number of words (sampled on start; 0 -> immediate done)
//   busy           out  transfer in progress
//   done           out  one-cycle end-of-transfer pulse
//   rd_addr        out  SDRAM read request address
//   rd_valid       out  SDRAM read request valid
//   rd_ready       in   SDRAM read request accepted
//   rd_data        in   returned SDRAM word (request order)
//   rd_data_valid  in   return strobe, never back-pressured
//   usb_fifoaddr   out  FX2 FIFOADR (fixed to EP_ADDR)
//   usb_slcs       out  FX2 chip select, active low
//   usb_sloe       out  FX2 output enable, active low (held inactive)
//   usb_slrd       out  FX2 read strobe, active low (held inactive)
//   usb_slwr       out  FX2 write strobe, active low
//   usb_pktend     out  FX2 packet end, active low
//   usb_fd_o       out  data towards the FX2
//   usb_fd_oe      out  1 while the FPGA drives the FX2 data bus
//   usb_flagb      in   EP6 full flag, active low
// ---------------------------------------------------------------------------
module sdram2cyp_tx
  import cyp_bridge_pkg::*;
#(
  parameter int         ADDR_W     = ADDR_W_DEF,
  parameter int         DATA_W     = DATA_W_DEF,
  parameter int         LEN_W      = 22,
  parameter int         FIFO_DEPTH = 16,
  parameter int         PKT_WORDS  = 256,
  parameter logic [1:0] EP_ADDR    = FIFOADR_EP6
) (
  input  logic              cyp_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  xfer_len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  input  logic              rd_ready,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_data_valid,
  output logic [1:0]        usb_fifoaddr,
  output logic              usb_slcs,
  output logic              usb_sloe,
  output logic              usb_slrd,
  output logic              usb_slwr,
  output logic              usb_pktend,
  output logic [DATA_W-1:0] usb_fd_o,
  output logic              usb_fd_oe,
  input  logic              usb_flagb
);

  localparam int              CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int              PKT_LOG = $clog2(PKT_WORDS);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  tx_state_e         state_q;
  tx_state_e         state_next;

  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  req_q;
  logic [LEN_W-1:0]  req_next;
  logic [LEN_W-1:0]  sent_q;
  logic [CNT_W-1:0]  out_q;
  logic [CNT_W-1:0]  out_next;
  logic [CNT_W-1:0]  count_next;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_valid_q;

  logic              busy_q;
  logic              done_q;
  logic              slcs_q;
  logic              slwr_q;
  logic              pktend_q;
  logic [DATA_W-1:0] fd_o_q;
  logic              fd_oe_q;

  logic              start_ok;
  logic              zero_len;
  logic              hs;
  logic              ret;
  logic              pop;
  logic              active_next;
  logic              rd_valid_next;
  logic              pktend_next;
  logic              pkt_short;

  logic [DATA_W-1:0] fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              unused_fifo_full;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (cyp_clk),
    .rst_n     (rst_n),
    .push      (ret),
    .push_data (rd_data),
    .pop       (pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (unused_fifo_full)
  );

  // A length that is not a whole number of packets leaves a short packet
  // sitting in the FX2 endpoint buffer.
  assign pkt_short = (len_q[PKT_LOG-1:0] != '0);

`ifdef SDRAM2CYP_PKTEND_EN
  logic pkt_done_q;
`else
  logic unused_pkt_short;
  assign unused_pkt_short = pkt_short;
`endif

  // Next-state logic plus the per-cycle request/return/write decisions.
  // Returns are only accepted while reads are genuinely outstanding, which
  // drops stray data that arrives after a reset aborted a transfer.
  always_comb begin
    state_next  = state_q;
    pktend_next = 1'b1;
    start_ok    = start && (state_q == ST_IDLE);
    zero_len    = start_ok && (xfer_len == '0);
    hs          = rd_valid_q && rd_ready;
    ret         = rd_data_valid && (state_q == ST_XFER) && (out_q != '0);
    pop         = (state_q == ST_XFER) && !fifo_empty && usb_flagb && (sent_q != len_q);

    case (state_q)
      ST_IDLE: begin
        if (start_ok && !zero_len) begin
          state_next = ST_SEL;
        end
      end
      ST_SEL: begin
        state_next = ST_XFER;
      end
      ST_XFER: begin
        if (sent_q == len_q) begin
          state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
`ifdef SDRAM2CYP_PKTEND_EN
        if (pkt_short && !pkt_done_q) begin
          if (usb_flagb) begin
            pktend_next = 1'b0;
          end
        end else begin
          state_next = ST_DONE;
        end
`else
        state_next = ST_DONE;
`endif
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    active_next = (state_next == ST_SEL) || (state_next == ST_XFER) || (state_next == ST_FLUSH);

    // Credit check looks at the post-edge occupancy so a request already on
    // the bus stays valid: the sum can only fall while rd_valid waits.
    req_next      = req_q + LEN_W'(hs);
    out_next      = out_q + CNT_W'(hs) - CNT_W'(ret);
    count_next    = fifo_count + CNT_W'(ret) - CNT_W'(pop);
    rd_valid_next = (state_next == ST_XFER) && (req_next < len_q) &&
                    ((out_next + count_next) < DEPTH_C);
  end

  // State register and every registered output.
  always_ff @(posedge cyp_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      req_q      <= '0;
      sent_q     <= '0;
      out_q      <= '0;
      rd_addr_q  <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      slcs_q     <= 1'b1;
      slwr_q     <= 1'b1;
      pktend_q   <= 1'b1;
      fd_o_q     <= '0;
      fd_oe_q    <= 1'b0;
`ifdef SDRAM2CYP_PKTEND_EN
      pkt_done_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_next;
      busy_q     <= active_next;
      done_q     <= (state_next == ST_DONE) || zero_len;
      slcs_q     <= !active_next;
      fd_oe_q    <= active_next;
      slwr_q     <= !pop;
      pktend_q   <= pktend_next;
      rd_valid_q <= rd_valid_next;
      if (pop) begin
        fd_o_q <= fifo_head;
      end
      if (start_ok) begin
        rd_addr_q <= base_addr;
        len_q     <= xfer_len;
        req_q     <= '0;
        sent_q    <= '0;
        out_q     <= '0;
      end else begin
        if (hs) begin
          rd_addr_q <= rd_addr_q + ADDR_W'(1);
        end
        req_q <= req_next;
        out_q <= out_next;
        if (pop) begin
          sent_q <= sent_q + LEN_W'(1);
        end
      end
`ifdef SDRAM2CYP_PKTEND_EN
      if (start_ok) begin
        pkt_done_q <= 1'b0;
      end else if (!pktend_next) begin
        pkt_done_q <= 1'b1;
      end
`endif
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign rd_addr      = rd_addr_q;
  assign rd_valid     = rd_valid_q;
  assign usb_fifoaddr = EP_ADDR;
  assign usb_slcs     = slcs_q;
  assign usb_sloe     = 1'b1;
  assign usb_slrd     = 1'b1;
  assign usb_slwr     = slwr_q;
  assign usb_pktend   = pktend_q;
  assign usb_fd_o     = fd_o_q;
  assign usb_fd_oe    = fd_oe_q;

endmodule

// File: tb/tb_sdram2cyp_tx.sv
// ---------------------------------------------------------------------------
// tb_sdram2cyp_tx
//   Self-checking bench for sdram2cyp_tx: an SDRAM read model with adjustable
//   latency and request back-pressure, an FX2 slave-FIFO model that can hold
//   FLAGB low, a table of transfers, and hand-written reset / zero-length
//   sequences. Honours SDRAM2CYP_PKTEND_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_sdram2cyp_tx;

  localparam int ADDR_W     = 22;
  localparam int DATA_W     = 16;
  localparam int LEN_W      = 22;
  localparam int FIFO_DEPTH = 16;
  localparam int PKT_WORDS  = 256;

`ifdef SDRAM2CYP_PKTEND_EN
  localparam bit PKTEND_ON = 1'b1;
`else
  localparam bit PKTEND_ON = 1'b0;
`endif

  logic              cyp_clk = 1'b0;
  logic              rst_n   = 1'b1;
  logic              start   = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  xfer_len  = '0;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic              rd_ready      = 1'b1;
  logic [DATA_W-1:0] rd_data       = '0;
  logic              rd_data_valid = 1'b0;
  logic [1:0]        usb_fifoaddr;
  logic              usb_slcs;
  logic              usb_sloe;
  logic              usb_slrd;
  logic              usb_slwr;
  logic              usb_pktend;
  logic [DATA_W-1:0] usb_fd_o;
  logic              usb_fd_oe;
  logic              usb_flagb = 1'b1;

  sdram2cyp_tx #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .LEN_W      (LEN_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .PKT_WORDS  (PKT_WORDS),
    .EP_ADDR    (2'b10)
  ) dut (
    .cyp_clk       (cyp_clk),
    .rst_n         (rst_n),
    .start         (start),
    .base_addr     (base_addr),
    .xfer_len      (xfer_len),
    .busy          (busy),
    .done          (done),
    .rd_addr       (rd_addr),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .usb_fifoaddr  (usb_fifoaddr),
    .usb_slcs      (usb_slcs),
    .usb_sloe      (usb_sloe),
    .usb_slrd      (usb_slrd),
    .usb_slwr      (usb_slwr),
    .usb_pktend    (usb_pktend),
    .usb_fd_o      (usb_fd_o),
    .usb_fd_oe     (usb_fd_oe),
    .usb_flagb     (usb_flagb)
  );

  always #5 cyp_clk = ~cyp_clk;

  // SDRAM content is a fixed scramble of the address.
  function automatic logic [DATA_W-1:0] memWord(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    w = a[15:0] ^ 16'h5A3C;
    w = w + {10'd0, a[21:16]};
    return w;
  endfunction

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                due;
  } rd_req_t;

  // Read-model state, owned by the posedge process.
  rd_req_t           pend[$];
  logic [ADDR_W-1:0] hs_addrs[$];
  int                cyc      = 0;
  int                accepted = 0;
  logic              flagb_at_edge = 1'b1;

  // Settings written by the stimulus process, read by the read model.
  int lat        = 2;
  int ready_mode = 0;

  // Monitor state, owned by the stimulus process.
  logic [DATA_W-1:0] wr_data[$];
  int full_writes = 0;
  int pktend_cnt  = 0;
  int done_cnt    = 0;
  int max_credit  = 0;
  int acc0        = 0;
  int hs0         = 0;
  int stall_at    = -1;
  int stall_len   = 0;
  int stall_left  = 0;
  bit stall_done  = 1'b0;

  int checks = 0;
  int passes = 0;

  // SDRAM model: capture handshakes on the edge, then drive the return path
  // and request back-pressure 1 ns later.
  always @(posedge cyp_clk) begin
    cyc++;
    flagb_at_edge = usb_flagb;
    if (rd_valid && rd_ready) begin
      pend.push_back('{addr: rd_addr, due: cyc + lat - 1});
      hs_addrs.push_back(rd_addr);
      accepted++;
    end
    #1;
    rd_data_valid = 1'b0;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      rd_data       = memWord(pend[0].addr);
      rd_data_valid = 1'b1;
      void'(pend.pop_front());
    end
    rd_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // One cycle: sample outputs at the falling edge and run the FX2 model.
  task automatic tick();
    int cur;
    @(negedge cyp_clk);
    if (rst_n) begin
      if (!usb_slwr) begin
        wr_data.push_back(usb_fd_o);
        if (!flagb_at_edge) full_writes++;
      end
      if (!usb_pktend) pktend_cnt++;
      if (done) done_cnt++;
      cur = (accepted - acc0) - wr_data.size();
      if (cur > max_credit) max_credit = cur;
    end
    if (stall_left > 0) begin
      stall_left--;
      if (stall_left == 0) usb_flagb = 1'b1;
    end else if (stall_at >= 0 && !stall_done && wr_data.size() == stall_at) begin
      usb_flagb  = 1'b0;
      stall_left = stall_len;
      stall_done = 1'b1;
    end
  endtask

  task automatic resetMonitor(input int l, input int mode, input int s_at, input int s_len);
    wr_data.delete();
    full_writes = 0;
    pktend_cnt  = 0;
    done_cnt    = 0;
    max_credit  = 0;
    acc0        = accepted;
    hs0         = hs_addrs.size();
    lat         = l;
    ready_mode  = mode;
    stall_at    = s_at;
    stall_len   = s_len;
    stall_left  = 0;
    stall_done  = 1'b0;
  endtask

  // Runs one complete transfer; an optional extra start pulse is fired while busy.
  task automatic applyStimulus(input logic [ADDR_W-1:0] base, input int len, input int l, input int mode,
                               input int s_at, input int s_len, input bit poke, output bit timed_out);
    bit seen;
    resetMonitor(l, mode, s_at, s_len);
    base_addr = base;
    xfer_len  = LEN_W'(len);
    start     = 1'b1;
    tick();
    start = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      if (poke && i == 10) begin
        base_addr = '0;
        xfer_len  = LEN_W'(3);
        start     = 1'b1;
      end
      tick();
      start = 1'b0;
      if (done) seen = 1'b1;
    end
    timed_out = !seen;
    repeat (3) tick();
  endtask

  task automatic verifyTransfer(input string name, input logic [ADDR_W-1:0] base, input int len,
                                input int exp_pktend, input bit full_credit, input bit timed_out);
    int data_bad;
    int addr_bad;
    int n;
    data_bad = 0;
    addr_bad = 0;
    n = (wr_data.size() < len) ? wr_data.size() : len;
    for (int i = 0; i < n; i++) begin
      if (wr_data[i] !== memWord(ADDR_W'(base + ADDR_W'(i)))) data_bad++;
    end
    n = ((hs_addrs.size() - hs0) < len) ? (hs_addrs.size() - hs0) : len;
    for (int i = 0; i < n; i++) begin
      if (hs_addrs[hs0 + i] !== ADDR_W'(base + ADDR_W'(i))) addr_bad++;
    end
    checkOutput({name, "_timeout"},   timed_out, 0);
    checkOutput({name, "_writes"},    wr_data.size(), len);
    checkOutput({name, "_data_bad"},  data_bad, 0);
    checkOutput({name, "_requests"},  hs_addrs.size() - hs0, len);
    checkOutput({name, "_addr_bad"},  addr_bad, 0);
    checkOutput({name, "_done_cnt"},  done_cnt, 1);
    checkOutput({name, "_pktend"},    pktend_cnt, exp_pktend);
    checkOutput({name, "_full_wr"},   full_writes, 0);
    checkOutput({name, "_credit_ok"}, (max_credit <= FIFO_DEPTH), 1);
    checkOutput({name, "_busy_end"},  busy, 0);
    if (full_credit) checkOutput({name, "_credit_max"}, max_credit, FIFO_DEPTH);
  endtask

  typedef struct {
    string             name;
    logic [ADDR_W-1:0] base;
    int                len;
    int                l;
    int                mode;
    int                s_at;
    int                s_len;
    bit                poke;
    int                exp_pktend;
    bit                full_credit;
  } vec_t;

  localparam logic [48:0] RESET_VEC = {3'b000, 22'h0, 2'b10, 5'b11111, 16'h0, 1'b0};

  function automatic logic [48:0] outVec();
    return {busy, done, rd_valid, rd_addr, usb_fifoaddr, usb_slcs, usb_sloe, usb_slrd,
            usb_slwr, usb_pktend, usb_fd_o, usb_fd_oe};
  endfunction

  initial begin
    vec_t vecs[6];
    bit   to;
    bit   reached;

    vecs[0] = '{"basic8",     22'h000100,   8, 2,  0, -1, 0, 1'b0, PKTEND_ON ? 1 : 0, 1'b0};
    vecs[1] = '{"len300_stall",22'h002000, 300, 2,  1, 40, 5, 1'b0, PKTEND_ON ? 1 : 0, 1'b0};
    vecs[2] = '{"lat20",      22'h000500,  40, 20, 0, -1, 0, 1'b0, PKTEND_ON ? 1 : 0, 1'b1};
    vecs[3] = '{"len512",     22'h000000, 512, 3,  0, -1, 0, 1'b0, 0,                 1'b0};
    vecs[4] = '{"wrap",       22'h3FFFFE,   4, 2,  0, -1, 0, 1'b0, PKTEND_ON ? 1 : 0, 1'b0};
    vecs[5] = '{"busy_start", 22'h000040,  20, 2,  0, -1, 0, 1'b1, PKTEND_ON ? 1 : 0, 1'b0};

    #2 rst_n = 1'b0;
    repeat (3) tick();
    checkOutput("reset_values", outVec(), RESET_VEC);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].base, vecs[v].len, vecs[v].l, vecs[v].mode,
                    vecs[v].s_at, vecs[v].s_len, vecs[v].poke, to);
      verifyTransfer(vecs[v].name, vecs[v].base, vecs[v].len, vecs[v].exp_pktend, vecs[v].full_credit, to);
    end

    // Zero-length start: done on the very next cycle, never busy, no writes.
    resetMonitor(2, 0, -1, 0);
    base_addr = 22'h000300;
    xfer_len  = '0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("len0_done",  done, 1);
    checkOutput("len0_busy",  busy, 0);
    tick();
    checkOutput("len0_done_clear", done, 0);
    repeat (3) tick();
    checkOutput("len0_writes",   wr_data.size(), 0);
    checkOutput("len0_requests", hs_addrs.size() - hs0, 0);

    // Reset in the middle of a 100-word transfer, then a fresh short transfer.
    resetMonitor(2, 0, -1, 0);
    base_addr = 22'h000800;
    xfer_len  = LEN_W'(100);
    start     = 1'b1;
    tick();
    start   = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 1000 && !reached; i++) begin
      tick();
      if (wr_data.size() >= 50) reached = 1'b1;
    end
    checkOutput("midreset_reach50", reached, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_values", outVec(), RESET_VEC);
    repeat (3) tick();
    checkOutput("midreset_hold", outVec(), RESET_VEC);
    rst_n = 1'b1;
    repeat (30) tick();
    checkOutput("midreset_idle", {busy, usb_slwr, usb_fd_oe}, 3'b010);
    applyStimulus(22'h000900, 4, 2, 0, -1, 0, 1'b0, to);
    verifyTransfer("after_reset", 22'h000900, 4, PKTEND_ON ? 1 : 0, 1'b0, to);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
